// File: rtl/apb_ahb3lite_master.sv
// APB slave to AHB3-Lite master bridge: each APB access becomes one or more
// unpipelined AHB SINGLE transfers, with sparse write strobes split into aligned pieces.
module apb_ahb3lite_master #(
  parameter int                    HADDR_SIZE = 32,
  parameter int                    PADDR_SIZE = 16,
  parameter int                    DATA_SIZE  = 32,
  parameter logic [HADDR_SIZE-1:0] HADDR_BASE = {HADDR_SIZE{1'b0}}
) (
  input  logic                   HRESETn,
  input  logic                   HCLK,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic [PADDR_SIZE-1:0]  PADDR,
  input  logic                   PWRITE,
  input  logic [DATA_SIZE-1:0]   PWDATA,
  input  logic [DATA_SIZE/8-1:0] PSTRB,
  input  logic [2:0]             PPROT,
  output logic [DATA_SIZE-1:0]   PRDATA,
  output logic                   PREADY,
  output logic                   PSLVERR,
  output logic [HADDR_SIZE-1:0]  HADDR,
  output logic                   HWRITE,
  output logic [2:0]             HSIZE,
  output logic [2:0]             HBURST,
  output logic [3:0]             HPROT,
  output logic [1:0]             HTRANS,
  output logic                   HMASTLOCK,
  output logic [DATA_SIZE-1:0]   HWDATA,
  input  logic [DATA_SIZE-1:0]   HRDATA,
  input  logic                   HREADY,
  input  logic                   HRESP
);

  localparam int NB = DATA_SIZE / 8;
  localparam int SW = $clog2(NB);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_ERR  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Lowest remaining strobe byte and the largest naturally aligned run of set
  // bytes starting there; packed as {size[2:0], index[2:0]}.
  function automatic logic [5:0] piece_of(input logic [NB-1:0] m);
    int   idx;
    int   sz;
    logic found;
    logic fits;
    idx   = 0;
    found = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if (!found && m[b]) begin
        idx   = b;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    sz   = 0;
    fits = 1'b1;
    for (int s = 1; s <= SW; s++) begin
      if ((idx % (1 << s)) != 0) fits = 1'b0;
      else                       fits = fits;
      for (int k = 0; k < NB; k++) begin
        if ((k >= idx) && (k < idx + (1 << s)) && !m[k]) fits = 1'b0;
        else                                              fits = fits;
      end
      if (fits) sz = s;
      else      sz = sz;
    end
    return {3'(sz), 3'(idx)};
  endfunction

  function automatic logic [NB-1:0] mask_of(input logic [5:0] p);
    logic [NB-1:0] m;
    int            idx;
    int            len;
    idx = int'(p[2:0]);
    len = 1 << p[5:3];
    for (int k = 0; k < NB; k++) begin
      m[k] = (k >= idx) && (k < idx + len);
    end
    return m;
  endfunction

  logic [2:0]            state_q,   state_d;
  logic [PADDR_SIZE-1:0] paddr_q,   paddr_d;
  logic                  hwrite_q,  hwrite_d;
  logic [NB-1:0]         strb_q,    strb_d;
  logic [NB-1:0]         pmask_q,   pmask_d;
  logic                  err_q,     err_d;
  logic [DATA_SIZE-1:0]  rdata_q,   rdata_d;
  logic [HADDR_SIZE-1:0] haddr_q,   haddr_d;
  logic [2:0]            hsize_q,   hsize_d;
  logic [3:0]            hprot_q,   hprot_d;
  logic [1:0]            htrans_q,  htrans_d;
  logic [DATA_SIZE-1:0]  hwdata_q,  hwdata_d;
  logic                  pready_q,  pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_SIZE-1:0]  prdata_q,  prdata_d;

  logic [NB-1:0]         strb_left_s;
  logic [5:0]            piece_s;
  logic                  pprot_unused_s;

  // PPROT[1] (secure/non-secure) has no AHB3-Lite counterpart.
  assign pprot_unused_s = PPROT[1];
  assign strb_left_s    = strb_q & ~pmask_q;

  // Next-state, piece selection and registered-output computation.
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    hwrite_d = hwrite_q;
    strb_d   = strb_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    hwdata_d = hwdata_q;
    hprot_d  = hprot_q;

    case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          paddr_d  = PADDR;
          hwrite_d = PWRITE;
          hwdata_d = PWDATA;
          strb_d   = PWRITE ? PSTRB : {NB{1'b1}};
          hprot_d  = {2'b00, PPROT[0], ~PPROT[2]};
          err_d    = 1'b0;
          rdata_d  = {DATA_SIZE{1'b0}};
          state_d  = (PWRITE && (PSTRB == {NB{1'b0}})) ? ST_DONE : ST_ADDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        state_d = HREADY ? ST_DATA : ST_ADDR;
      end
      ST_DATA: begin
        if (HRESP) begin
          // Error aborts the access: remaining pieces are dropped.
          err_d   = 1'b1;
          strb_d  = {NB{1'b0}};
          state_d = HREADY ? ST_DONE : ST_ERR;
        end else if (HREADY) begin
          if (!hwrite_q) rdata_d = HRDATA;
          else           rdata_d = rdata_q;
          strb_d  = strb_left_s;
          state_d = (strb_left_s != {NB{1'b0}}) ? ST_ADDR : ST_DONE;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_ERR: begin
        state_d = HREADY ? ST_DONE : ST_ERR;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    piece_s = piece_of(strb_d);
    if (state_d == ST_ADDR) begin
      haddr_d = HADDR_BASE
              | (HADDR_SIZE'(paddr_d) & ~HADDR_SIZE'(NB - 1))
              | HADDR_SIZE'(piece_s[2:0]);
      hsize_d = piece_s[5:3];
      pmask_d = mask_of(piece_s);
    end else begin
      haddr_d = haddr_q;
      hsize_d = hsize_q;
      pmask_d = pmask_q;
    end

    htrans_d = (state_d == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    pready_d = (state_d == ST_DONE);
    if (state_d == ST_DONE) begin
      pslverr_d = err_d;
      prdata_d  = hwrite_d ? {DATA_SIZE{1'b0}} : rdata_d;
    end else begin
      pslverr_d = 1'b0;
      prdata_d  = {DATA_SIZE{1'b0}};
    end
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= ST_IDLE;
      paddr_q   <= {PADDR_SIZE{1'b0}};
      hwrite_q  <= 1'b0;
      strb_q    <= {NB{1'b0}};
      pmask_q   <= {NB{1'b0}};
      err_q     <= 1'b0;
      rdata_q   <= {DATA_SIZE{1'b0}};
      haddr_q   <= {HADDR_SIZE{1'b0}};
      hsize_q   <= 3'd0;
      hprot_q   <= 4'd0;
      htrans_q  <= HTRANS_IDLE;
      hwdata_q  <= {DATA_SIZE{1'b0}};
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= {DATA_SIZE{1'b0}};
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      hwrite_q  <= hwrite_d;
      strb_q    <= strb_d;
      pmask_q   <= pmask_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      haddr_q   <= haddr_d;
      hsize_q   <= hsize_d;
      hprot_q   <= hprot_d;
      htrans_q  <= htrans_d;
      hwdata_q  <= hwdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  assign HADDR     = haddr_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HBURST    = 3'b000;
  assign HPROT     = hprot_q;
  assign HTRANS    = htrans_q;
  assign HMASTLOCK = 1'b0;
  assign HWDATA    = hwdata_q;
  assign PREADY    = pready_q;
  assign PSLVERR   = pslverr_q;
  assign PRDATA    = prdata_q;

endmodule

// File: doc/apb_ahb3lite_master.md
APB_AHB3LITE_MASTER -- requirements
Module: apb_ahb3lite_master

Interface
REQ-001 Parameters: HADDR_SIZE, 32, AHB address width; PADDR_SIZE, 16, APB address width (≤HADDR_SIZE); DATA_SIZE, 32, APB and AHB data width (32 or 64); HADDR_BASE, 0, value OR'ed onto zero-extended PADDR to form HADDR.
REQ-002 HRESETn  in  1  reset, asynchronous, active-low; HCLK  in  1  clock, shared by the APB and AHB sides.
REQ-003 APB slave inputs: PSEL 1; PENABLE 1; PADDR PADDR_SIZE; PWRITE 1; PWDATA DATA_SIZE; PSTRB DATA_SIZE/8; PPROT 3.
REQ-004 APB slave outputs: PRDATA DATA_SIZE, read data; PREADY 1, transfer done; PSLVERR 1, transfer error.
REQ-005 AHB master outputs: HADDR HADDR_SIZE; HWRITE 1; HSIZE 3; HBURST 3; HPROT 4; HTRANS 2; HMASTLOCK 1; HWDATA DATA_SIZE.
REQ-006 AHB master inputs: HRDATA DATA_SIZE; HREADY 1; HRESP 1.

Function
REQ-007 The FSM SHALL have states IDLE, ADDR (AHB address phase), DATA (AHB data phase), ERR (second error cycle), DONE (PREADY cycle).
REQ-008 In IDLE, on PSEL=1 and PENABLE=0, the block SHALL latch PADDR, PWRITE, PWDATA, PSTRB (forced to all-ones for reads) and PPROT, then go to ADDR; for a write with PSTRB=0 it SHALL go directly to DONE.
REQ-009 Each write SHALL be split into AHB SINGLE transfers: take the lowest set remaining strobe bit i; choose the largest size 2^s bytes with i mod 2^s = 0 and bits i..i+2^s-1 all set; issue with HSIZE=s, HADDR={word-aligned address}+i; clear those bits; repeat until no bits remain.
REQ-010 A read SHALL be a single full-width transfer: HSIZE=log2(DATA_SIZE/8), HADDR word-aligned.
REQ-011 In ADDR: HTRANS=NONSEQ, HBURST=SINGLE, HMASTLOCK=0, HWRITE=latched PWRITE; hold until HREADY=1, then go to DATA.
REQ-012 In DATA: HTRANS=IDLE; HWDATA=latched PWDATA unchanged (little-endian byte lanes); on HREADY=1 and HRESP=0, capture HRDATA for reads, then go to ADDR if strobe bits remain, otherwise to DONE.
REQ-013 No address-phase pipelining SHALL be used: at least one HTRANS=IDLE cycle separates successive pieces.
REQ-014 In DATA with HRESP=1 and HREADY=0, the block SHALL go to ERR, drive HTRANS=IDLE, record the error and discard remaining pieces; ERR SHALL proceed to DONE on HREADY=1.
REQ-015 In DONE the block SHALL drive PREADY=1 for exactly one cycle, with PSLVERR=error flag and PRDATA=captured data (0 for writes), then return to IDLE.
REQ-016 PREADY SHALL be 0 in every other state; PSLVERR and PRDATA SHALL be 0 whenever PREADY=0.
REQ-017 HPROT SHALL be {2'b00, PPROT[0], ~PPROT[2]}: non-cacheable, non-bufferable; privileged from PPROT[0]; data/opcode from PPROT[2]. PPROT[1] SHALL be ignored.
REQ-018 HADDR SHALL be HADDR_BASE | zero-extended PADDR; all HADDR/HSIZE/HWRITE/HPROT outputs SHALL be registered and stable throughout ADDR.
REQ-019 APB setups arriving while not in IDLE are protocol violations and SHALL be ignored; PREADY SHALL be issued only for the latched transfer.

Reset
REQ-020 On HRESETn=0, immediately and at any point mid-transfer: state IDLE, HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HBURST=0, HPROT=0, HMASTLOCK=0, HWDATA=0, PREADY=0, PSLVERR=0, PRDATA=0, internal latches cleared.
REQ-021 After reset release, the first transfer SHALL start only on a fresh APB setup cycle.

Verification
REQ-022 Word write, PADDR=0x10, PSTRB=0xF, PWDATA=0xA5A5_5A5A, HREADY=1 -> one NONSEQ, HADDR=0x10, HSIZE=2, HWDATA=0xA5A55A5A; PREADY=1 three cycles after setup; PSLVERR=0.
REQ-023 Write PSTRB=0xB (DATA_SIZE=32), PADDR=0x20 -> two transfers: HADDR=0x20 HSIZE=1, then HADDR=0x23 HSIZE=0; one PREADY pulse.
REQ-024 Read, PADDR=0x44, HRDATA=0x1234_5678, HREADY held low 2 cycles in the data phase -> PRDATA=0x12345678 with PREADY=1; PREADY stays low during the wait states.
REQ-025 Write PSTRB=0x5 with HRESP=1 on the first piece (ERROR, 2 cycles) -> HTRANS=IDLE in the first error cycle, second piece not issued, PREADY=1 with PSLVERR=1.
REQ-026 Write PSTRB=0 -> no HTRANS=NONSEQ, PREADY=1 with PSLVERR=0; HRESETn asserted during ADDR of another write -> HTRANS=IDLE and PREADY=0 immediately, and the block is IDLE after release.
